eth_tx_framer: RTL and testbench
================================

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL provide parameter pMII_WIDTH, default 2, PHY data lines per symbol; legal values 2 (RMII), 4 (MII), 8 (GMII-style).
REQ-002 SHALL provide parameter pIPG_BYTES, default 12, inter-packet gap in byte times.
REQ-003 SHALL provide parameter pMIN_PKT_BYTES, default 60, minimum frame bytes DEST..PAD excluding FCS.
REQ-004 Clk  in  1  single clock; one PHY symbol per cycle.
REQ-005 Rst  in  1  reset, asynchronous, active-high.
REQ-006 Dest_Addr  in  48  destination MAC, first-transmitted byte in [7:0]; sampled at frame start.
REQ-007 Src_Addr  in  48  source MAC, same byte order; sampled at frame start.
REQ-008 Len_Type  in  16  length/type, byte [15:8] sent first; sampled at frame start.
REQ-009 Data_In  in  8  payload byte.
REQ-010 Data_Valid  in  1  Data_In valid.
REQ-011 Data_Last  in  1  Data_In is final payload byte.
REQ-012 Data_Ready  out  1  framer consumes Data_In this cycle.
REQ-013 Txd  out  pMII_WIDTH  PHY transmit data.
REQ-014 Tx_En  out  1  PHY transmit enable.
REQ-015 Busy  out  1  high in every state except IDLE.
REQ-016 Underrun  out  1  one-cycle pulse on payload starvation.

Function
REQ-017 SHALL implement states IDLE, PREAMBLE, SFD, DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA, PAD, FCS, IPG, in that order; PAD skipped when not needed.
REQ-018 Byte duration SHALL be 8/pMII_WIDTH cycles; each state lasts its byte count (7,1,6,6,2,n,pad,4,pIPG_BYTES) times that.
REQ-019 Bytes SHALL be shifted LSB first; Txd = low pMII_WIDTH bits of the active byte.
REQ-020 IDLE with Data_Valid=1 SHALL latch Dest_Addr/Src_Addr/Len_Type and enter PREAMBLE next cycle; Data_In is not consumed then.
REQ-021 PREAMBLE SHALL send 0x55 bytes; SFD SHALL send 0xD5.
REQ-022 Txd and Tx_En SHALL be registered; Tx_En high from the first PREAMBLE symbol through the last FCS symbol, low otherwise.
REQ-023 In DATA, Data_Ready SHALL assert only in the cycle a new byte is loaded (first DATA cycle, then every 8/pMII_WIDTH cycles); byte accepted when Data_Valid&&Data_Ready.
REQ-024 Data_Ready SHALL be 0 in all non-DATA states, including IPG.
REQ-025 On accepting a byte with Data_Last=1, after that byte the FSM SHALL go to PAD if byte count (DEST..DATA) < pMIN_PKT_BYTES, else FCS.
REQ-026 PAD SHALL send 0x00 until byte count equals pMIN_PKT_BYTES.
REQ-027 Byte counter SHALL be 11 bits and saturate at 2047; no frame-length upper limit is enforced.
REQ-028 Data_Ready=1 with Data_Valid=0 SHALL pulse Underrun, drop Tx_En next cycle, skip PAD/FCS and enter IPG.
REQ-029 IPG SHALL drive Txd=0, Tx_En=0 for pIPG_BYTES*8/pMII_WIDTH cycles, then IDLE; a new frame may start the cycle IDLE is entered.

Reset
REQ-030 Rst assertion SHALL immediately force state IDLE, Txd=0, Tx_En=0, Data_Ready=0, Busy=0, Underrun=0, all counters and CRC to reset values, also mid-frame.
REQ-031 Frame in progress at Rst SHALL be discarded without Underrun; first frame after deassertion needs no IPG.

Configuration
REQ-032 Macro ETH_TX_FCS_EN defined: CRC-32 (reflected poly 0x04C11DB7, init 0xFFFFFFFF, final complement) SHALL be computed over DEST..PAD and sent in FCS, LSB first.
REQ-033 Macro ETH_TX_FCS_EN undefined: no CRC logic; FCS skipped, Tx_En falls after last DATA/PAD symbol, then IPG.

Verification
REQ-034 pMII_WIDTH=2, 46-byte payload 0x00..0x2D, FCS_EN -> Tx_En high 288 cycles (72 bytes), Txd preamble 2'b01 x28, SFD ends 2'b11, no PAD, then 48 IPG cycles.
REQ-035 pMII_WIDTH=2, 1-byte payload 0xAB, FCS_EN -> 45 PAD 0x00 bytes, 60 bytes pre-FCS, FCS matches reference CRC-32 of the 60 bytes.
REQ-036 pMII_WIDTH=8, 100-byte payload -> Data_Ready every cycle in DATA, Tx_En high 126 cycles, IPG 12 cycles.
REQ-037 pMII_WIDTH=4, Data_Valid dropped at payload byte 5 -> Underrun one cycle, Tx_En low next cycle, 24 IPG cycles, Busy low after.
REQ-038 Rst pulse during SRC_ADDR -> Tx_En, Txd, Busy 0 same cycle; next frame starts with preamble, no IPG.
REQ-039 ETH_TX_FCS_EN undefined, 46-byte payload, pMII_WIDTH=2 -> Tx_En high 272 cycles, no FCS.

Source files
------------

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: Ethernet MAC transmit framer (preamble, SFD, header, payload, pad, IPG) for RMII/MII/GMII-style PHYs.
// Optional macro ETH_TX_FCS_EN appends the CRC-32 frame check sequence.
module eth_tx_framer #(
  parameter int pMII_WIDTH     = 2,
  parameter int pIPG_BYTES     = 12,
  parameter int pMIN_PKT_BYTES = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [47:0]           dest_addr,
  input  logic [47:0]           src_addr,
  input  logic [15:0]           len_type,
  input  logic [7:0]            data_in,
  input  logic                  data_valid,
  input  logic                  data_last,
  output logic                  data_ready,
  output logic [pMII_WIDTH-1:0] txd,
  output logic                  tx_en,
  output logic                  busy,
  output logic                  underrun,
  output logic [3:0]            dbg_state
);
  localparam int SPB = 8 / pMII_WIDTH;
  localparam int SW  = (SPB > 1) ? $clog2(SPB) : 1;
  localparam logic [SW-1:0] SYM_LAST = SW'(SPB - 1);
  localparam logic [10:0]   MIN_CNT  = 11'(pMIN_PKT_BYTES);
  localparam logic [15:0]   GAP_CYC  = 16'(pIPG_BYTES * SPB);
  localparam logic [15:0]   GAP_M1   = 16'(pIPG_BYTES * SPB - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DEST, S_SRC, S_LEN, S_DATA, S_PAD, S_FCS, S_IPG
  } state_t;

`ifdef ETH_TX_FCS_EN
  localparam state_t S_AFTER = S_FCS;
`else
  localparam state_t S_AFTER = S_IPG;
`endif

  state_t         state;
  logic [SW-1:0]  sym;
  logic [2:0]     fcnt;
  logic [15:0]    gap;
  logic [10:0]    frame_cnt;
  logic [111:0]   hdr_q;
  logic [7:0]     cur_q;
  logic           last_q;

  logic                  sym0, byte_end, accept, last_now, pad_needed;
  logic [7:0]            new_byte, byte_src;
  logic [10:0]           cnt_inc, cnt_now;
  logic [pMII_WIDTH-1:0] sym_out;

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc_q, crc_nxt;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign crc_nxt = crc_byte(crc_q, new_byte);
`endif

  // Handshake: a payload byte transfers on the clock edge where data_valid && data_ready.
  // data_ready is high only on the first symbol of each DATA byte; ready without valid is an underrun.
  always_comb begin
    sym0       = (sym == '0);
    byte_end   = (sym == SYM_LAST);
    data_ready = (state == S_DATA) && sym0;
    accept     = data_ready && data_valid;
    underrun   = data_ready && !data_valid;
    busy       = (state != S_IDLE);
    dbg_state  = state;
    case (state)
      S_PREAMBLE:            new_byte = 8'h55;
      S_SFD:                 new_byte = 8'hD5;
      S_DEST, S_SRC, S_LEN:  new_byte = hdr_q[7:0];
      S_DATA:                new_byte = data_in;
`ifdef ETH_TX_FCS_EN
      S_FCS:                 new_byte = ~crc_q[7:0];
`endif
      default:               new_byte = 8'h00;
    endcase
    byte_src   = sym0 ? new_byte : cur_q;
    sym_out    = byte_src[pMII_WIDTH-1:0];
    cnt_inc    = (frame_cnt == 11'h7FF) ? frame_cnt : frame_cnt + 11'd1;
    // A byte loaded this very cycle is already part of the frame count.
    cnt_now    = sym0 ? cnt_inc : frame_cnt;
    last_now   = sym0 ? data_last : last_q;
    pad_needed = (cnt_now < MIN_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sym       <= '0;
      fcnt      <= '0;
      gap       <= '0;
      frame_cnt <= '0;
      hdr_q     <= '0;
      cur_q     <= '0;
      last_q    <= 1'b0;
      txd       <= '0;
      tx_en     <= 1'b0;
`ifdef ETH_TX_FCS_EN
      crc_q     <= 32'hFFFFFFFF;
`endif
    end else begin
      txd   <= '0;
      tx_en <= 1'b0;
      if ((state inside {[S_PREAMBLE:S_FCS]}) && !underrun) begin
        txd   <= sym_out;
        tx_en <= 1'b1;
      end

      if (state != S_IDLE && state != S_IPG) begin
        sym   <= byte_end ? '0 : sym + SW'(1);
        cur_q <= sym0 ? (new_byte >> pMII_WIDTH) : (cur_q >> pMII_WIDTH);
      end

      if (sym0) begin
        if (state inside {S_DEST, S_SRC, S_LEN}) hdr_q <= hdr_q >> 8;
        if ((state inside {S_DEST, S_SRC, S_LEN, S_PAD}) || accept) begin
          frame_cnt <= cnt_inc;
`ifdef ETH_TX_FCS_EN
          crc_q     <= crc_nxt;
`endif
        end
        if (accept) last_q <= data_last;
`ifdef ETH_TX_FCS_EN
        if (state == S_FCS) crc_q <= crc_q >> 8;
`endif
      end

      case (state)
        S_IDLE: if (data_valid) begin
          state     <= S_PREAMBLE;
          sym       <= '0;
          fcnt      <= '0;
          frame_cnt <= '0;
          last_q    <= 1'b0;
          hdr_q     <= {len_type[7:0], len_type[15:8], src_addr, dest_addr};
`ifdef ETH_TX_FCS_EN
          crc_q     <= 32'hFFFFFFFF;
`endif
        end
        S_PREAMBLE: if (byte_end) begin
          if (fcnt == 3'd6) begin state <= S_SFD; fcnt <= '0; end
          else fcnt <= fcnt + 3'd1;
        end
        S_SFD: if (byte_end) begin state <= S_DEST; fcnt <= '0; end
        S_DEST: if (byte_end) begin
          if (fcnt == 3'd5) begin state <= S_SRC; fcnt <= '0; end
          else fcnt <= fcnt + 3'd1;
        end
        S_SRC: if (byte_end) begin
          if (fcnt == 3'd5) begin state <= S_LEN; fcnt <= '0; end
          else fcnt <= fcnt + 3'd1;
        end
        S_LEN: if (byte_end) begin
          if (fcnt == 3'd1) begin state <= S_DATA; fcnt <= '0; end
          else fcnt <= fcnt + 3'd1;
        end
        S_DATA: begin
          // Starvation already blanked the output, so the gap starts one cycle shorter.
          if (underrun) begin
            state <= S_IPG;
            gap   <= GAP_M1;
          end else if (byte_end && last_now) begin
            if (pad_needed) state <= S_PAD;
            else begin state <= S_AFTER; fcnt <= '0; gap <= GAP_CYC; end
          end
        end
        S_PAD: if (byte_end && !pad_needed) begin
          state <= S_AFTER;
          fcnt  <= '0;
          gap   <= GAP_CYC;
        end
        S_FCS: if (byte_end) begin
          if (fcnt == 3'd3) begin state <= S_IPG; gap <= GAP_CYC; end
          else fcnt <= fcnt + 3'd1;
        end
        S_IPG: begin
          if (gap == 16'd0) state <= S_IDLE;
          else gap <= gap - 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: three instances (2/4/8-bit PHY), byte capture on the 2-bit bus, counters per instance.
module tb_eth_tx_framer;
`ifdef ETH_TX_FCS_EN
  localparam int FCSB = 4;
`else
  localparam int FCSB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [47:0] dest_addr = 48'h665544332211;
  logic [47:0] src_addr  = 48'hCCBBAA998877;
  logic [15:0] len_type  = 16'h0800;
  logic [7:0]  din [3];
  logic        dv [3], dl [3], dr [3], und [3], en [3], bsy [3];
  logic [3:0]  st [3];
  logic [1:0]  txd2;
  logic [3:0]  txd4;
  logic [7:0]  txd8;

  int total = 0, bad = 0;
  int en_cnt [3], gap_cnt [3], und_cnt [3], rdy_cnt [3], dcyc_cnt [3], cyc [3], first_en [3];
  logic seen_en [3], und_d [3], en_after_und [3];
  logic [7:0] cap_q [$];
  logic [7:0] asm_b;
  int asm_n;

  eth_tx_framer #(.pMII_WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .dest_addr(dest_addr), .src_addr(src_addr), .len_type(len_type),
    .data_in(din[0]), .data_valid(dv[0]), .data_last(dl[0]), .data_ready(dr[0]),
    .txd(txd2), .tx_en(en[0]), .busy(bsy[0]), .underrun(und[0]), .dbg_state(st[0]));
  eth_tx_framer #(.pMII_WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .dest_addr(dest_addr), .src_addr(src_addr), .len_type(len_type),
    .data_in(din[1]), .data_valid(dv[1]), .data_last(dl[1]), .data_ready(dr[1]),
    .txd(txd4), .tx_en(en[1]), .busy(bsy[1]), .underrun(und[1]), .dbg_state(st[1]));
  eth_tx_framer #(.pMII_WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .dest_addr(dest_addr), .src_addr(src_addr), .len_type(len_type),
    .data_in(din[2]), .data_valid(dv[2]), .data_last(dl[2]), .data_ready(dr[2]),
    .txd(txd8), .tx_en(en[2]), .busy(bsy[2]), .underrun(und[2]), .dbg_state(st[2]));

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      cyc[k]++;
      if (en[k]) begin
        en_cnt[k]++;
        seen_en[k] = 1'b1;
        if (first_en[k] < 0) first_en[k] = cyc[k];
      end
      if (bsy[k] && !en[k] && seen_en[k]) gap_cnt[k]++;
      if (und[k]) und_cnt[k]++;
      if (und_d[k]) en_after_und[k] = en[k];
      und_d[k] = und[k];
      if (st[k] == 4'd6) begin
        dcyc_cnt[k]++;
        if (dr[k]) rdy_cnt[k]++;
      end
    end
    if (en[0]) begin
      asm_b = {txd2, asm_b[7:2]};
      asm_n++;
      if (asm_n == 4) begin
        cap_q.push_back(asm_b);
        asm_n = 0;
      end
    end else begin
      asm_n = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input int first, input int n);
    logic [31:0] c;
    logic [7:0] b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = cap_q[first + i];
      for (int j = 0; j < 8; j++) c = (c[0] ^ b[j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic clear_stats(input int k);
    en_cnt[k] = 0; gap_cnt[k] = 0; und_cnt[k] = 0; rdy_cnt[k] = 0; dcyc_cnt[k] = 0;
    cyc[k] = 0; first_en[k] = -1; seen_en[k] = 1'b0; und_d[k] = 1'b0; en_after_und[k] = 1'b1;
    if (k == 0) begin
      cap_q.delete();
      asm_n = 0;
    end
  endtask

  // Payload byte i is base+i; drop_at is the payload index at which valid is withheld (-1: never).
  task automatic send_frame(input int k, input int plen, input int drop_at, input logic [7:0] base);
    int idx, guard;
    logic acc, stv;
    @(posedge clk); #1;
    clear_stats(k);
    idx = 0;
    din[k] = base; dv[k] = 1'b1; dl[k] = (plen == 1);
    guard = 0;
    while (guard < 4000) begin
      @(negedge clk);
      acc = dr[k] && dv[k];
      stv = dr[k] && !dv[k];
      @(posedge clk); #1;
      guard++;
      if (stv) break;
      if (acc) begin
        idx++;
        if (idx == plen) break;
        din[k] = base + 8'(idx);
        dv[k]  = (idx != drop_at);
        dl[k]  = (idx == plen - 1);
      end
    end
    dv[k] = 1'b0; dl[k] = 1'b0;
    check("send_bound", 32'(guard < 4000), 1);
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (bsy[k] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("idle_bound", 32'(n < 4000), 1);
  endtask

  initial begin
    int nbad, n;
    for (int k = 0; k < 3; k++) begin
      din[k] = 8'h00; dv[k] = 1'b0; dl[k] = 1'b0;
      clear_stats(k);
    end
    asm_b = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", 32'(en[0]), 0);
    check("rst_txd", 32'(txd2), 0);
    check("rst_busy", 32'(bsy[0]), 0);
    check("rst_ready", 32'(dr[0]), 0);
    check("rst_underrun", 32'(und[0]), 0);
    rst = 1'b0;

    // 2-bit bus, 46-byte payload: no pad, minimum-size frame
    send_frame(0, 46, -1, 8'h00);
    wait_idle(0);
    check("a_en_cycles", en_cnt[0], (68 + FCSB) * 4);
    check("a_bytes", cap_q.size(), 68 + FCSB);
    nbad = 0;
    for (int i = 0; i < 7; i++) if (cap_q[i] !== 8'h55) nbad++;
    check("a_preamble", nbad, 0);
    check("a_sfd", cap_q[7], 8'hD5);
    check("a_dest0", cap_q[8], 8'h11);
    check("a_dest5", cap_q[13], 8'h66);
    check("a_src0", cap_q[14], 8'h77);
    check("a_len_hi", cap_q[20], 8'h08);
    check("a_len_lo", cap_q[21], 8'h00);
    nbad = 0;
    for (int i = 0; i < 46; i++) if (cap_q[22 + i] !== 8'(i)) nbad++;
    check("a_payload", nbad, 0);
`ifdef ETH_TX_FCS_EN
    check("a_fcs", {cap_q[71], cap_q[70], cap_q[69], cap_q[68]}, ref_crc(8, 60));
`endif
    check("a_ipg", gap_cnt[0], 48);
    check("a_underrun", und_cnt[0], 0);

    // 2-bit bus, 1-byte payload: 45 pad bytes
    send_frame(0, 1, -1, 8'hAB);
    wait_idle(0);
    check("b_bytes", cap_q.size(), 68 + FCSB);
    check("b_data", cap_q[22], 8'hAB);
    nbad = 0;
    for (int i = 23; i < 68; i++) if (cap_q[i] !== 8'h00) nbad++;
    check("b_pad", nbad, 0);
`ifdef ETH_TX_FCS_EN
    check("b_fcs", {cap_q[71], cap_q[70], cap_q[69], cap_q[68]}, ref_crc(8, 60));
`endif
    check("b_en_cycles", en_cnt[0], (68 + FCSB) * 4);

    // 8-bit bus, 100-byte payload: ready every DATA cycle
    send_frame(2, 100, -1, 8'h10);
    wait_idle(2);
    check("c_data_cycles", dcyc_cnt[2], 100);
    check("c_ready_cycles", rdy_cnt[2], 100);
    check("c_en_cycles", en_cnt[2], 122 + FCSB);
    check("c_ipg", gap_cnt[2], 12);

    // 4-bit bus, valid withheld at payload byte 5
    send_frame(1, 46, 5, 8'h00);
    wait_idle(1);
    check("d_underrun", und_cnt[1], 1);
    check("d_en_after_und", 32'(en_after_und[1]), 0);
    check("d_en_cycles", en_cnt[1], 54);
    check("d_ipg", gap_cnt[1], 24);
    check("d_busy_after", 32'(bsy[1]), 0);

    // 2-bit bus, reset pulse while sending the source address
    @(posedge clk); #1;
    clear_stats(0);
    din[0] = 8'h00; dv[0] = 1'b1; dl[0] = 1'b0;
    n = 0;
    while (st[0] != 4'd4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("e_reach_src", 32'(n < 500), 1);
    check("e_en_before", 32'(en[0]), 1);
    rst = 1'b1; dv[0] = 1'b0;
    #1;
    check("e_rst_tx_en", 32'(en[0]), 0);
    check("e_rst_txd", 32'(txd2), 0);
    check("e_rst_busy", 32'(bsy[0]), 0);
    check("e_no_underrun", und_cnt[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(0, 46, -1, 8'h00);
    wait_idle(0);
    check("e_start_latency", first_en[0], 3);
    check("e_first_byte", cap_q[0], 8'h55);
    check("e_bytes", cap_q.size(), 68 + FCSB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
